// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: WM8731-style I2C write target that ACKs 3-byte frames and strobes each register write.
module i2c_codec_responder #(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sclk,
   input  logic       i_sdat,
   output logic       o_sdat_oe,
   output logic       o_reg_valid,
   output logic [6:0] o_reg_addr,
   output logic [8:0] o_reg_data,
   output logic       o_busy,
   output logic       o_frame_err
);
   typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP} state_t;
   state_t state;
   logic [SYNC_STAGES:0] scl_q, sda_q;
   logic [7:0] sh, b1, b2, nxt;
   logic [2:0] cnt;
   logic extra, scl_c, scl_p, sda_c, sda_p, rise, fall, start, stop, rx_state, ack_state;
   assign scl_c = scl_q[SYNC_STAGES-1];
   assign scl_p = scl_q[SYNC_STAGES];
   assign sda_c = sda_q[SYNC_STAGES-1];
   assign sda_p = sda_q[SYNC_STAGES];
   assign rise  = !scl_p && scl_c;
   assign fall  = scl_p && !scl_c;
   assign start = scl_p && scl_c && sda_p && !sda_c;
   assign stop  = scl_p && scl_c && !sda_p && sda_c;
   assign rx_state  = state == ADDR || state == BYTE1 || state == BYTE2;
   assign ack_state = state == ACK_A || state == ACK_1 || state == ACK_2;
   assign nxt = {sh[6:0], sda_c};
   // Sync flops reset to the idle-bus level so reset release cannot fake a START/STOP
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[SYNC_STAGES-1:0], i_sclk};
         sda_q <= {sda_q[SYNC_STAGES-1:0], i_sdat};
      end
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         sh          <= '0;
         b1          <= '0;
         b2          <= '0;
         cnt         <= '0;
         extra       <= 1'b0;
         o_sdat_oe   <= 1'b0;
         o_reg_valid <= 1'b0;
         o_reg_addr  <= '0;
         o_reg_data  <= '0;
         o_busy      <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_reg_valid <= 1'b0;
         o_frame_err <= 1'b0;
         if (start) begin
            state     <= ADDR;
            cnt       <= '0;
            sh        <= '0;
            extra     <= 1'b0;
            o_busy    <= 1'b1;
            o_sdat_oe <= 1'b0;
         end else if (stop) begin
            state     <= IDLE;
            cnt       <= '0;
            o_busy    <= 1'b0;
            o_sdat_oe <= 1'b0;
            if (state == WAIT_STOP && !extra) begin
               o_reg_valid <= 1'b1;
               o_reg_addr  <= b1[7:1];
               o_reg_data  <= {b1[0], b2};
            end else if (state != IDLE)
               o_frame_err <= 1'b1;
         end else if (rise && rx_state) begin
            sh  <= nxt;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
               if (state == ADDR) begin
                  state  <= (nxt == {DEV_ADDR, 1'b0}) ? ACK_A : IDLE;
                  o_busy <= nxt == {DEV_ADDR, 1'b0};
               end else if (state == BYTE1) begin
                  b1    <= nxt;
                  state <= ACK_1;
               end else begin
                  b2    <= nxt;
                  state <= ACK_2;
               end
            end
         end else if (rise && state == WAIT_STOP) begin
            // Only a full 8th bit marks an extra byte; the SCL rise ahead of STOP does not
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7)
               extra <= 1'b1;
         end else if (fall && ack_state) begin
            o_sdat_oe <= !o_sdat_oe;
            if (o_sdat_oe)
               state <= (state == ACK_A) ? BYTE1 : (state == ACK_1) ? BYTE2 : WAIT_STOP;
         end
      end
   end
endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb_i2c_codec_responder: directed I2C master frames against the codec responder with hand-computed results.
`timescale 1ns/1ps
module tb_i2c_codec_responder;
   localparam time Q = 100ns;
   logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
   logic sda, oe, valid, busy, ferr, oe_q;
   logic [6:0] raddr, la;
   logic [8:0] rdata, ld;
   int n_cmp = 0, n_bad = 0, acnt, vcnt, ecnt, mack;
   assign sda = ~(m_low | oe);
   always #5 clk = ~clk;
   i2c_codec_responder dut (
      .i_clk(clk), .i_rst(rst), .i_sclk(scl), .i_sdat(sda),
      .o_sdat_oe(oe), .o_reg_valid(valid), .o_reg_addr(raddr), .o_reg_data(rdata),
      .o_busy(busy), .o_frame_err(ferr)
   );
   always @(negedge clk) begin
      if (rst) oe_q = 1'b0;
      else begin
         if (valid) begin
            vcnt++;
            la = raddr;
            ld = rdata;
         end
         if (ferr) ecnt++;
         if (oe && !oe_q) acnt++;
         oe_q = oe;
      end
   end
   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic clr();
      acnt = 0; vcnt = 0; ecnt = 0; mack = 0;
   endtask
   task automatic i2c_start();
      m_low = 1'b0; #Q scl = 1'b1; #Q m_low = 1'b1; #Q scl = 1'b0; #Q;
   endtask
   task automatic i2c_stop();
      m_low = 1'b1; #Q scl = 1'b1; #Q m_low = 1'b0; #Q;
   endtask
   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         m_low = !b[i]; #Q scl = 1'b1; #(2*Q) scl = 1'b0; #Q;
      end
   endtask
   task automatic put(input logic [7:0] b);
      send_bits(b);
      m_low = 1'b0; #Q scl = 1'b1; #Q mack += int'(!sda); #Q scl = 1'b0; #Q;
   endtask
   task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      i2c_start(); put(a); put(b); put(c); i2c_stop();
   endtask
   initial begin
      clr();
      la = '0; ld = '0;
      #23;
      check("rst_oe", oe, 0); check("rst_valid", valid, 0); check("rst_busy", busy, 0);
      check("rst_err", ferr, 0); check("rst_addr", raddr, 0); check("rst_data", rdata, 0);
      #10 rst = 1'b0; #100;
      clr();
      i2c_start();
      check("t1_busy_on", busy, 1);
      put(8'h34); put(8'h1E); put(8'h00); i2c_stop();
      check("t1_mack", mack, 3); check("t1_acks", acnt, 3); check("t1_valid", vcnt, 1);
      check("t1_err", ecnt, 0); check("t1_addr", la, 7'h0F); check("t1_data", ld, 9'h000);
      check("t1_busy_off", busy, 0);
      clr();
      frame(8'h34, 8'h00, 8'h97);
      check("t2a_addr", la, 7'h00); check("t2a_data", ld, 9'h097);
      frame(8'h34, 8'h08, 8'h15);
      check("t2_valid", vcnt, 2); check("t2b_addr", la, 7'h04); check("t2b_data", ld, 9'h015);
      check("t2_err", ecnt, 0);
      clr();
      i2c_start(); put(8'h36);
      check("t3_busy", busy, 0);
      put(8'h12); put(8'h34); i2c_stop();
      check("t3_mack", mack, 0); check("t3_acks", acnt, 0); check("t3_valid", vcnt, 0); check("t3_err", ecnt, 0);
      clr();
      i2c_start(); put(8'h34); put(8'h0C); i2c_stop();
      check("t4_mack", mack, 2); check("t4_acks", acnt, 2); check("t4_err", ecnt, 1); check("t4_valid", vcnt, 0);
      check("t4_addr", raddr, 7'h04); check("t4_data", rdata, 9'h015);
      clr();
      i2c_start(); put(8'h34); put(8'h0C); i2c_start(); put(8'h34); put(8'h0D); put(8'h01); i2c_stop();
      check("t5_mack", mack, 5); check("t5_valid", vcnt, 1); check("t5_err", ecnt, 0);
      check("t5_addr", la, 7'h06); check("t5_data", ld, 9'h101);
      clr();
      i2c_start(); put(8'h34); put(8'h1E); put(8'h00); put(8'hAA); i2c_stop();
      check("t7_mack", mack, 3); check("t7_err", ecnt, 1); check("t7_valid", vcnt, 0);
      clr();
      i2c_start(); put(8'h34); send_bits(8'h12);
      check("t6_ack_on", oe, 1);
      #3 rst = 1'b1;
      #1 check("t6_async_oe", oe, 0); check("t6_busy", busy, 0);
      #20 rst = 1'b0; m_low = 1'b0; #Q;
      clr();
      frame(8'h34, 8'h12, 8'h01);
      check("t6_mack", mack, 3); check("t6_valid", vcnt, 1);
      check("t6_addr", la, 7'h09); check("t6_data", ld, 9'h001);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
